dlx_mem_arbiter: RTL and testbench
==================================

// Module: dlx_mem_arbiter
// PURPOSE
//  Shares one single-ported, variable-latency memory between the DLX instruction fetch port (IAddr/IRead/IIn)
//  and the data port (DAddr/DRead/DWrite/DOut/DIn). It freezes the five-stage pipeline with Stall while it
//  serves the requests, one after the other: data access first, because MEM is the older stage, then
//  instruction fetch. It sits between the dlx core and the external memory model and replaces the split caches.
// PARAMETERS
//  WIDTH    32  data/address width (matches core word size)
//  TIMEOUT  15  max wait cycles for MReady per access before a bus error; legal range 1..255
//  CNTW     16  width of the saturating stall-cycle counter
// PORTS
//  PHI1      in   1      single-phase clock; all state changes on rising edge
//  MRST      in   1      master reset, synchronous, active-high
//  IRead     in   1      core instruction fetch request
//  IAddr     in   WIDTH  fetch address
//  IIn       out  WIDTH  fetched instruction to core (registered)
//  DRead     in   1      core data read request
//  DWrite    in   1      core data write request
//  DAddr     in   WIDTH  data address
//  DOut      in   WIDTH  store data from core
//  DIn       out  WIDTH  load data to core (registered)
//  Stall     out  1      freeze all pipeline registers this cycle
//  MReq      out  1      memory access request (registered)
//  MWr       out  1      1=write, 0=read; valid while MReq=1
//  MAddr     out  WIDTH  memory address; valid while MReq=1
//  MWData    out  WIDTH  memory write data; valid while MReq=1 and MWr=1
//  MRData    in   WIDTH  memory read data; valid with MReady
//  MReady    in   1      memory completes current access this cycle
//  BusErr    out  1      sticky: an access timed out; cleared only by MRST
//  ProtErr   out  1      sticky: DRead and DWrite were seen together; cleared only by MRST
//  StallCnt  out  CNTW   saturating count of cycles with Stall=1
// BEHAVIOUR
//  Reset: state=IDLE; MReq=0, MWr=0, MAddr=0, MWData=0; IIn=0, DIn=0; BusErr=0, ProtErr=0, StallCnt=0.
//   An MReady that arrives after reset for an access aborted by reset is ignored.
//  FSM states: IDLE, DATA, INST, DONE.
//  Stall = (state!=DONE) & (IRead|DRead|DWrite). This is combinational. While Stall=1 the core holds
//   all request and address inputs stable.
//  IDLE:
//   - If DRead|DWrite: go to DATA. Next cycle MReq=1, MAddr=DAddr, MWr=DWrite, MWData=DOut.
//   - Else if IRead: go to INST with MReq=1, MAddr=IAddr, MWr=0.
//   - Else: stay in IDLE with MReq=0.
//  DATA:
//   - On MReady: MReq drops next cycle. If it was a read, DIn<=MRData.
//   - Then go to INST if IRead=1 (new fetch request loaded in the same edge), else go to DONE.
//  INST: on MReady, IIn<=MRData and go to DONE.
//  DONE: Stall=0 for exactly one cycle, so the pipeline advances on this edge using the registered IIn/DIn.
//   Then go to IDLE.
//  Minimum service time is 1 issue cycle + 1 memory cycle per access + 1 DONE cycle.
//   Example: a fetch plus a load with zero-wait memory takes Stall=1 for 3 cycles, then Stall=0 for 1 cycle.
//  Wait counter:
//   - Reset to 0 on every access issue; increments each cycle with MReq=1 and MReady=0.
//   - If it reaches TIMEOUT: BusErr<=1, the access is aborted (MReq=0 next cycle), and the
//     destination register (DIn or IIn) is loaded with 0. The FSM proceeds exactly as if MReady had come.
//  DRead&DWrite at the same time: treated as a write; ProtErr<=1.
//  MReady while MReq=0: ignored. MReady is sampled only in DATA or INST.
//  StallCnt increments on every cycle with Stall=1 and saturates at all-ones (no wrap).
//  MRST asserted in any state: all the reset values above apply on that edge, regardless of MReady.
// TESTING
//  1. Zero-wait memory (MReady tied 1); IRead=1 only, IAddr=0x100, MRData=0x20010005
//     -> Stall 1,1,0; MReq 1 for 1 cycle; IIn=0x20010005 in the DONE cycle; StallCnt=2.
//  2. Load + fetch: DRead=1 DAddr=0x40, IRead=1 IAddr=0x104; memory returns 0xDEADBEEF then 0x00000000
//     -> MAddr order 0x40 then 0x104; DIn=0xDEADBEEF, IIn=0; Stall high 3 cycles then low 1 cycle.
//  3. Store with 3 wait states: DWrite=1 DAddr=0x80 DOut=0x1234
//     -> MReq=1, MWr=1, MWData=0x1234 held 4 cycles; DIn unchanged; BusErr=0.
//  4. MReady never asserted, TIMEOUT=15 -> after 15 waiting cycles BusErr=1, IIn=0, FSM reaches DONE;
//     BusErr stays 1 until MRST.
//  5. MRST pulsed while in DATA with a wait state, then MReady=1 in the next cycle
//     -> state IDLE, MReq=0, DIn stays 0, StallCnt=0.
//  6. DRead=DWrite=1 together -> a write access is issued and ProtErr=1. Separately, force Stall high for
//     70000 cycles with CNTW=16 -> StallCnt=0xFFFF.

Source files
------------

// File: rtl/dlx_mem_arbiter_if.sv
//------------------------------------------------------------------------------
// Module      : dlx_mem_arbiter_if
// Description : Core-side and memory-side bus bundle of the DLX memory arbiter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dlx_mem_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
);
  // core instruction port
  logic             iread;
  logic [WIDTH-1:0] iaddr;
  logic [WIDTH-1:0] iin;
  // core data port
  logic             dread;
  logic             dwrite;
  logic [WIDTH-1:0] daddr;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] din;
  logic             stall;
  // external memory
  logic             mreq;
  logic             mwr;
  logic [WIDTH-1:0] maddr;
  logic [WIDTH-1:0] mwdata;
  logic [WIDTH-1:0] mrdata;
  logic             mready;
  // status
  logic             bus_err;
  logic             prot_err;
  logic [CNTW-1:0]  stall_cnt;

  modport slave (
    input  iread, iaddr, dread, dwrite, daddr, dout, mrdata, mready,
    output iin, din, stall, mreq, mwr, maddr, mwdata, bus_err, prot_err, stall_cnt
  );

  modport master (
    output iread, iaddr, dread, dwrite, daddr, dout, mrdata, mready,
    input  iin, din, stall, mreq, mwr, maddr, mwdata, bus_err, prot_err, stall_cnt
  );
endinterface

`default_nettype wire

// File: rtl/dlx_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : dlx_mem_arbiter
// Description : Serialises DLX data and fetch requests onto one variable-latency
//               memory, stalling the pipeline until both are served.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dlx_mem_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15,
  parameter int CNTW    = 16
) (
  input wire               clk,
  input wire               rst,
  dlx_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_INST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [7:0] c_wait_limit = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_mreq,      w_mreq_nxt;
  logic             r_mwr,       w_mwr_nxt;
  logic [WIDTH-1:0] r_maddr,     w_maddr_nxt;
  logic [WIDTH-1:0] r_mwdata,    w_mwdata_nxt;
  logic [WIDTH-1:0] r_iin,       w_iin_nxt;
  logic [WIDTH-1:0] r_din,       w_din_nxt;
  logic [7:0]       r_wait_cnt,  w_wait_nxt;
  logic             r_bus_err;
  logic             r_prot_err;
  logic [CNTW-1:0]  r_stall_cnt;

  logic w_any_req;
  logic w_data_req;
  logic w_stall;
  logic w_serving;
  logic w_timeout;
  logic w_finish;

  assign w_any_req  = bus.iread | bus.dread | bus.dwrite;
  assign w_data_req = bus.dread | bus.dwrite;
  assign w_stall    = (r_state != ST_DONE) & w_any_req;

  // MReady only counts while an access is actually outstanding; a real
  // MReady on the last allowed cycle wins over the timeout.
  assign w_serving  = ((r_state == ST_DATA) | (r_state == ST_INST)) & r_mreq;
  assign w_timeout  = w_serving & ~bus.mready & (r_wait_cnt == c_wait_limit);
  assign w_finish   = w_serving & (bus.mready | w_timeout);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mreq      <= 1'b0;
      r_mwr       <= 1'b0;
      r_maddr     <= '0;
      r_mwdata    <= '0;
      r_iin       <= '0;
      r_din       <= '0;
      r_wait_cnt  <= '0;
      r_bus_err   <= 1'b0;
      r_prot_err  <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mreq     <= w_mreq_nxt;
      r_mwr      <= w_mwr_nxt;
      r_maddr    <= w_maddr_nxt;
      r_mwdata   <= w_mwdata_nxt;
      r_iin      <= w_iin_nxt;
      r_din      <= w_din_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_bus_err  <= r_bus_err | w_timeout;
      r_prot_err <= r_prot_err | (bus.dread & bus.dwrite);
      if (w_stall && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mreq_nxt   = r_mreq;
    w_mwr_nxt    = r_mwr;
    w_maddr_nxt  = r_maddr;
    w_mwdata_nxt = r_mwdata;
    w_iin_nxt    = r_iin;
    w_din_nxt    = r_din;
    w_wait_nxt   = r_wait_cnt;

    if (r_mreq && !bus.mready) begin
      w_wait_nxt = r_wait_cnt + 8'd1;
    end

    unique case (r_state)
      ST_IDLE: begin
        // Data first: MEM is the older pipeline stage. Simultaneous
        // read and write resolve to a write.
        if (w_data_req) begin
          w_state_nxt  = ST_DATA;
          w_mreq_nxt   = 1'b1;
          w_mwr_nxt    = bus.dwrite;
          w_maddr_nxt  = bus.daddr;
          w_mwdata_nxt = bus.dout;
          w_wait_nxt   = '0;
        end else if (bus.iread) begin
          w_state_nxt  = ST_INST;
          w_mreq_nxt   = 1'b1;
          w_mwr_nxt    = 1'b0;
          w_maddr_nxt  = bus.iaddr;
          w_wait_nxt   = '0;
        end
      end

      ST_DATA: begin
        if (w_finish) begin
          if (!r_mwr) begin
            w_din_nxt = w_timeout ? '0 : bus.mrdata;
          end
          if (bus.iread) begin
            w_state_nxt = ST_INST;
            w_mreq_nxt  = 1'b1;
            w_mwr_nxt   = 1'b0;
            w_maddr_nxt = bus.iaddr;
            w_wait_nxt  = '0;
          end else begin
            w_state_nxt = ST_DONE;
            w_mreq_nxt  = 1'b0;
          end
        end
      end

      ST_INST: begin
        if (w_finish) begin
          w_iin_nxt   = w_timeout ? '0 : bus.mrdata;
          w_state_nxt = ST_DONE;
          w_mreq_nxt  = 1'b0;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.stall     = w_stall;
  assign bus.mreq      = r_mreq;
  assign bus.mwr       = r_mwr;
  assign bus.maddr     = r_maddr;
  assign bus.mwdata    = r_mwdata;
  assign bus.iin       = r_iin;
  assign bus.din       = r_din;
  assign bus.bus_err   = r_bus_err;
  assign bus.prot_err  = r_prot_err;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dlx_mem_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_dlx_mem_arbiter
// Description : Scoreboard bench for dlx_mem_arbiter with a waiting memory model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dlx_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          len;
  } acc_t;

  typedef struct {
    logic [31:0] iin;
    logic [31:0] din;
    logic        bus_err;
    logic        prot_err;
    int          stalls;
    logic [15:0] cnt;
  } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dlx_mem_arbiter_if #(.WIDTH(32), .CNTW(16)) bus ();

  dlx_mem_arbiter #(.WIDTH(32), .TIMEOUT(15), .CNTW(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  acc_t        acc_q[$];
  done_t       done_q[$];
  logic [31:0] rd_q[$];
  int          mem_wait  = 0;
  bit          force_rdy = 1'b0;
  bit          mon_en    = 1'b1;
  int          exp_cnt   = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void exp_acc(logic [31:0] addr, logic wr, logic [31:0] wdata, int len);
    acc_t a;
    a.addr = addr; a.wr = wr; a.wdata = wdata; a.len = len;
    acc_q.push_back(a);
  endfunction

  function automatic void exp_done(logic [31:0] iin, logic [31:0] din, logic be, logic pe, int stalls);
    done_t d;
    exp_cnt += stalls;
    d.iin = iin; d.din = din; d.bus_err = be; d.prot_err = pe;
    d.stalls = stalls; d.cnt = 16'(exp_cnt);
    done_q.push_back(d);
  endfunction

  // Memory model: answers after mem_wait wait states, never when mem_wait < 0.
  initial begin
    int wcnt = 0;
    bus.mready = 1'b0;
    bus.mrdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (bus.mready) wcnt = 0;
      bus.mready = 1'b0;
      if (force_rdy) begin
        bus.mready = 1'b1;
        bus.mrdata = 32'hFFFF0000;
      end else if (bus.mreq) begin
        if (mem_wait >= 0 && wcnt == mem_wait) begin
          bus.mready = 1'b1;
          if (bus.mwr) bus.mrdata = 32'hBAD0BAD0;
          else bus.mrdata = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: memory completions and DONE cycles are checked against the queues.
  initial begin
    int    stall_run = 0;
    int    mreq_run  = 0;
    acc_t  a;
    done_t d;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        stall_run = 0;
        mreq_run  = 0;
      end else begin
        if (bus.stall) stall_run++;
        if (bus.mreq) mreq_run++;
        else mreq_run = 0;
        if (bus.mreq && bus.mready) begin
          if (acc_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_access: addr 0x%08h with nothing expected", bus.maddr);
          end else begin
            a = acc_q.pop_front();
            check("maddr", bus.maddr, a.addr);
            check("mwr", 32'(bus.mwr), 32'(a.wr));
            if (a.wr) check("mwdata", bus.mwdata, a.wdata);
            check("mreq_cycles", 32'(mreq_run), 32'(a.len));
          end
          mreq_run = 0;
        end
        if ((bus.iread || bus.dread || bus.dwrite) && !bus.stall) begin
          if (done_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: stall dropped with nothing expected");
          end else begin
            d = done_q.pop_front();
            check("iin", bus.iin, d.iin);
            check("din", bus.din, d.din);
            check("bus_err", 32'(bus.bus_err), 32'(d.bus_err));
            check("prot_err", 32'(bus.prot_err), 32'(d.prot_err));
            check("stall_cycles", 32'(stall_run), 32'(d.stalls));
            check("stall_cnt", 32'(bus.stall_cnt), 32'(d.cnt));
          end
          stall_run = 0;
        end
      end
    end
  end

  task automatic run_txn(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dd, input int wt);
    bit seen = 1'b0;
    mem_wait   = wt;
    bus.iread  = ir;
    bus.iaddr  = ia;
    bus.dread  = dr;
    bus.dwrite = dw;
    bus.daddr  = da;
    bus.dout   = dd;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!bus.stall) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL txn_complete: stall still 1 after 200 cycles, expected 0");
    end
    @(posedge clk);
    #1;
    bus.iread  = 1'b0;
    bus.dread  = 1'b0;
    bus.dwrite = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iread  = 1'b0;
    bus.iaddr  = '0;
    bus.dread  = 1'b0;
    bus.dwrite = 1'b0;
    bus.daddr  = '0;
    bus.dout   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mreq", 32'(bus.mreq), 32'h0);
    check("rst_mwr", 32'(bus.mwr), 32'h0);
    check("rst_maddr", bus.maddr, 32'h0);
    check("rst_mwdata", bus.mwdata, 32'h0);
    check("rst_iin", bus.iin, 32'h0);
    check("rst_din", bus.din, 32'h0);
    check("rst_bus_err", 32'(bus.bus_err), 32'h0);
    check("rst_prot_err", 32'(bus.prot_err), 32'h0);
    check("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    check("rst_stall", 32'(bus.stall), 32'h0);
    @(posedge clk);
    #1;

    // zero-wait fetch
    rd_q.push_back(32'h20010005);
    exp_acc(32'h100, 1'b0, 32'h0, 1);
    exp_done(32'h20010005, 32'h0, 1'b0, 1'b0, 2);
    run_txn(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 0);

    // load followed by fetch in one stall
    rd_q.push_back(32'hDEADBEEF);
    rd_q.push_back(32'h00000000);
    exp_acc(32'h40, 1'b0, 32'h0, 1);
    exp_acc(32'h104, 1'b0, 32'h0, 1);
    exp_done(32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 3);
    run_txn(1'b1, 32'h104, 1'b1, 1'b0, 32'h40, 32'h0, 0);

    // store with 3 wait states
    exp_acc(32'h80, 1'b1, 32'h1234, 4);
    exp_done(32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 5);
    run_txn(1'b0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h1234, 3);

    // fetch with 2 wait states
    rd_q.push_back(32'hA5A50001);
    exp_acc(32'h108, 1'b0, 32'h0, 3);
    exp_done(32'hA5A50001, 32'hDEADBEEF, 1'b0, 1'b0, 4);
    run_txn(1'b1, 32'h108, 1'b0, 1'b0, 32'h0, 32'h0, 2);

    // fetch that never completes: 1 issue + 15 waiting cycles
    exp_done(32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 16);
    run_txn(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, -1);

    // bus error stays set across a good load
    rd_q.push_back(32'h0BADF00D);
    exp_acc(32'h44, 1'b0, 32'h0, 2);
    exp_done(32'h0, 32'h0BADF00D, 1'b1, 1'b0, 3);
    run_txn(1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h0, 1);

    // reset during a waiting load, then a stray MReady
    mem_wait  = 1;
    bus.dread = 1'b1;
    bus.daddr = 32'h48;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.dread = 1'b0;
    force_rdy = 1'b1;
    exp_cnt   = 0;
    rd_q.delete();
    @(posedge clk);
    #1;
    force_rdy = 1'b0;
    @(negedge clk);
    check("mrst_mreq", 32'(bus.mreq), 32'h0);
    check("mrst_din", bus.din, 32'h0);
    check("mrst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    check("mrst_bus_err", 32'(bus.bus_err), 32'h0);
    @(negedge clk);
    check("mrst_mreq_idle", 32'(bus.mreq), 32'h0);
    @(posedge clk);
    #1;

    // read and write together resolve to a write
    exp_acc(32'h90, 1'b1, 32'h55AA, 1);
    exp_done(32'h0, 32'h0, 1'b0, 1'b1, 2);
    run_txn(1'b0, 32'h0, 1'b1, 1'b1, 32'h90, 32'h55AA, 0);

    // stall counter saturation
    mon_en    = 1'b0;
    mem_wait  = -1;
    bus.iread = 1'b1;
    bus.iaddr = 32'h300;
    repeat (70000) @(posedge clk);
    #1;
    bus.iread = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check("stall_cnt_sat", 32'(bus.stall_cnt), 32'h0000FFFF);
    check("sat_bus_err", 32'(bus.bus_err), 32'h1);
    check("sat_mreq", 32'(bus.mreq), 32'h0);

    check("acc_q_left", 32'(acc_q.size()), 32'h0);
    check("done_q_left", 32'(done_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
